wb_regfile_hilo: RTL and testbench

- Write-back consumer and register storage for the 5-stage MIPS core.
- Receives the 38-bit GPR commit bus and the 66-bit HI/LO commit bus from the WB stage. Holds the 32x32 GPR array and the HI/LO pair.
- Serves two GPR read ports and one HI/LO read port to ID, with same-cycle WB write-through bypass.
- Keeps a commit counter for debug and performance.

---
 rtl/wb_regfile_hilo_pkg.sv | 28 ++
 rtl/wb_regfile_hilo_if.sv | 27 ++
 rtl/wb_regfile_hilo_hilo_reg.sv | 43 ++++
 rtl/wb_regfile_hilo.sv | 59 +++++
 tb/tb_wb_regfile_hilo.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_hilo_pkg.sv
// Shared widths, commit-bus field positions and the hard-wired zero register
// index for the write-back register file block.
package wb_regfile_hilo_pkg;

  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 32;
  localparam int WB_TO_RF_WD = 38;
  localparam int HILO_BUS_WD = 66;

  // wb_to_rf_bus = {rf_we, rf_waddr, rf_wdata}
  localparam int RF_WE_BIT   = 37;
  localparam int RF_WADDR_HI = 36;
  localparam int RF_WADDR_LO = 32;
  localparam int RF_WDATA_HI = 31;
  localparam int RF_WDATA_LO = 0;

  // wb_to_hilo_bus = {hi_we, lo_we, hi_i, lo_i}
  localparam int HI_WE_BIT   = 65;
  localparam int LO_WE_BIT   = 64;
  localparam int HI_I_HI     = 63;
  localparam int HI_I_LO     = 32;
  localparam int LO_I_HI     = 31;
  localparam int LO_I_LO     = 0;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wb_regfile_hilo_if.sv
// WB commit buses, ID read ports and debug counters between the pipeline
// (master) and the register file (slave).
interface wb_regfile_hilo_if;
  import wb_regfile_hilo_pkg::*;

  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus;
  logic [HILO_BUS_WD-1:0] wb_to_hilo_bus;
  logic [ADDR_W-1:0]      raddr1;
  logic [ADDR_W-1:0]      raddr2;
  logic [DATA_W-1:0]      rdata1;
  logic [DATA_W-1:0]      rdata2;
  logic [DATA_W-1:0]      hi_o;
  logic [DATA_W-1:0]      lo_o;
  logic [CNT_W-1:0]       commit_cnt;
  logic [CNT_W-1:0]       hilo_cnt;

  modport master (
    output wb_to_rf_bus, wb_to_hilo_bus, raddr1, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, commit_cnt, hilo_cnt
  );

  modport slave (
    input  wb_to_rf_bus, wb_to_hilo_bus, raddr1, raddr2,
    output rdata1, rdata2, hi_o, lo_o, commit_cnt, hilo_cnt
  );

endinterface

// File: rtl/wb_regfile_hilo_hilo_reg.sv
// HI/LO pair: independent per-half writes, zero-latency write-through reads,
// and a count of cycles carrying any HI/LO commit. No backpressure.
module wb_regfile_hilo_hilo_reg
  import wb_regfile_hilo_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [HILO_BUS_WD-1:0] i_hilo_bus,
  output logic [DATA_W-1:0]      o_hi,
  output logic [DATA_W-1:0]      o_lo,
  output logic [CNT_W-1:0]       o_hilo_cnt
);

  logic              w_hi_we;
  logic              w_lo_we;
  logic [DATA_W-1:0] w_hi_i;
  logic [DATA_W-1:0] w_lo_i;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [CNT_W-1:0]  r_hilo_cnt;

  assign w_hi_we = i_hilo_bus[HI_WE_BIT];
  assign w_lo_we = i_hilo_bus[LO_WE_BIT];
  assign w_hi_i  = i_hilo_bus[HI_I_HI:HI_I_LO];
  assign w_lo_i  = i_hilo_bus[LO_I_HI:LO_I_LO];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_hilo_cnt <= '0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_i;
      if (w_lo_we) r_lo <= w_lo_i;
      if (w_hi_we || w_lo_we) r_hilo_cnt <= r_hilo_cnt + CNT_W'(1);
    end
  end

  assign o_hi       = w_hi_we ? w_hi_i : r_hi;
  assign o_lo       = w_lo_we ? w_lo_i : r_lo;
  assign o_hilo_cnt = r_hilo_cnt;

endmodule

// File: rtl/wb_regfile_hilo.sv
// 32x32 GPR file with two zero-latency write-through read ports, HI/LO pair
// and commit counters; consumes WB commits every cycle with no backpressure.
module wb_regfile_hilo
  import wb_regfile_hilo_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  wb_regfile_hilo_if.slave bus
);

  logic              w_rf_we;
  logic [ADDR_W-1:0] w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_rf_commit;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_lo;
  logic [CNT_W-1:0]  w_hilo_cnt;

  logic [DATA_W-1:0] r_gpr [2**ADDR_W];
  logic [CNT_W-1:0]  r_commit_cnt;

  assign w_rf_we     = bus.wb_to_rf_bus[RF_WE_BIT];
  assign w_rf_waddr  = bus.wb_to_rf_bus[RF_WADDR_HI:RF_WADDR_LO];
  assign w_rf_wdata  = bus.wb_to_rf_bus[RF_WDATA_HI:RF_WDATA_LO];
  // Writes to r0 are dropped entirely: no store, no bypass, no count.
  assign w_rf_commit = w_rf_we && (w_rf_waddr != ZERO_REG);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_gpr[i] <= '0;
      r_commit_cnt <= '0;
    end else if (w_rf_commit) begin
      r_gpr[w_rf_waddr] <= w_rf_wdata;
      r_commit_cnt      <= r_commit_cnt + CNT_W'(1);
    end
  end

  assign bus.rdata1 = (bus.raddr1 == ZERO_REG)                     ? '0         :
                      (w_rf_commit && (w_rf_waddr == bus.raddr1))  ? w_rf_wdata :
                                                                     r_gpr[bus.raddr1];
  assign bus.rdata2 = (bus.raddr2 == ZERO_REG)                     ? '0         :
                      (w_rf_commit && (w_rf_waddr == bus.raddr2))  ? w_rf_wdata :
                                                                     r_gpr[bus.raddr2];
  assign bus.commit_cnt = r_commit_cnt;

  wb_regfile_hilo_hilo_reg u_hilo (
    .clk        (clk),
    .resetn     (resetn),
    .i_hilo_bus (bus.wb_to_hilo_bus),
    .o_hi       (w_hi),
    .o_lo       (w_lo),
    .o_hilo_cnt (w_hilo_cnt)
  );

  assign bus.hi_o     = w_hi;
  assign bus.lo_o     = w_lo;
  assign bus.hilo_cnt = w_hilo_cnt;

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Self-checking bench for wb_regfile_hilo: directed scenarios plus randomized
// commits compared against an architectural register-file model.
module tb_wb_regfile_hilo;

  logic clk;
  logic resetn;
  wb_regfile_hilo_if u_if ();

  wb_regfile_hilo dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // architectural state
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo, m_cc, m_hc;

  // currently driven WB fields
  logic        t_rf_we, t_hwe, t_lwe;
  logic [4:0]  t_wa;
  logic [31:0] t_wd, t_hi, t_lo;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0; m_cc = '0; m_hc = '0;
  endtask

  task automatic set_bus(input logic rf_we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic hwe, input logic lwe, input logic [31:0] hi, input logic [31:0] lo);
    t_rf_we = rf_we; t_wa = wa; t_wd = wd; t_hwe = hwe; t_lwe = lwe; t_hi = hi; t_lo = lo;
    u_if.wb_to_rf_bus   = {rf_we, wa, wd};
    u_if.wb_to_hilo_bus = {hwe, lwe, hi, lo};
  endtask

  task automatic set_idle();
    set_bus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // advance one edge; the model commits only when reset is released at that edge
  task automatic tick();
    @(posedge clk);
    if (resetn) begin
      if (t_rf_we && t_wa != 5'd0) begin
        m_gpr[t_wa] = t_wd;
        m_cc = m_cc + 32'd1;
      end
      if (t_hwe) m_hi = t_hi;
      if (t_lwe) m_lo = t_lo;
      if (t_hwe || t_lwe) m_hc = m_hc + 32'd1;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (t_rf_we && t_wa == a) return t_wd;
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] exp_hi();
    return t_hwe ? t_hi : m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    return t_lwe ? t_lo : m_lo;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    set_idle();
    u_if.raddr1 = 5'd3;
    u_if.raddr2 = 5'd31;
    model_clear();
    #3;
    n_chk++; if (u_if.rdata1 !== 32'd0) begin n_fail++; $display("FAIL rst_rdata1: got %h want %h", u_if.rdata1, 32'd0); end
    n_chk++; if (u_if.rdata2 !== 32'd0) begin n_fail++; $display("FAIL rst_rdata2: got %h want %h", u_if.rdata2, 32'd0); end
    n_chk++; if (u_if.hi_o !== 32'd0) begin n_fail++; $display("FAIL rst_hi: got %h want %h", u_if.hi_o, 32'd0); end
    n_chk++; if (u_if.lo_o !== 32'd0) begin n_fail++; $display("FAIL rst_lo: got %h want %h", u_if.lo_o, 32'd0); end
    n_chk++; if (u_if.commit_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_commit_cnt: got %h want %h", u_if.commit_cnt, 32'd0); end
    n_chk++; if (u_if.hilo_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_hilo_cnt: got %h want %h", u_if.hilo_cnt, 32'd0); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    set_bus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    set_idle();
    u_if.raddr1 = 5'd5;
    #2;
    n_chk++; if (u_if.rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_r5: got %h want %h", u_if.rdata1, 32'hDEADBEEF); end
    n_chk++; if (u_if.commit_cnt !== 32'd1) begin n_fail++; $display("FAIL wr_rd_cnt: got %h want %h", u_if.commit_cnt, 32'd1); end
  endtask

  task automatic test_bypass();
    set_bus(1'b1, 5'd7, 32'h11, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    set_bus(1'b1, 5'd7, 32'h22, 1'b0, 1'b0, 32'd0, 32'd0);
    u_if.raddr1 = 5'd7;
    u_if.raddr2 = 5'd7;
    #2;
    n_chk++; if (u_if.rdata1 !== 32'h22) begin n_fail++; $display("FAIL byp_rdata1: got %h want %h", u_if.rdata1, 32'h22); end
    n_chk++; if (u_if.rdata2 !== 32'h22) begin n_fail++; $display("FAIL byp_rdata2: got %h want %h", u_if.rdata2, 32'h22); end
    tick();
    set_idle();
    #2;
    n_chk++; if (u_if.rdata1 !== 32'h22) begin n_fail++; $display("FAIL byp_stored: got %h want %h", u_if.rdata1, 32'h22); end
  endtask

  task automatic test_zero_reg();
    set_bus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 32'd0);
    u_if.raddr1 = 5'd0;
    #2;
    n_chk++; if (u_if.rdata1 !== 32'd0) begin n_fail++; $display("FAIL zero_during: got %h want %h", u_if.rdata1, 32'd0); end
    tick();
    set_idle();
    #2;
    n_chk++; if (u_if.rdata1 !== 32'd0) begin n_fail++; $display("FAIL zero_after: got %h want %h", u_if.rdata1, 32'd0); end
    n_chk++; if (u_if.commit_cnt !== 32'd3) begin n_fail++; $display("FAIL zero_cnt: got %h want %h", u_if.commit_cnt, 32'd3); end
  endtask

  task automatic test_hilo();
    set_bus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h1234, 32'h5555);
    #2;
    n_chk++; if (u_if.hi_o !== 32'h1234) begin n_fail++; $display("FAIL hilo_hi_byp: got %h want %h", u_if.hi_o, 32'h1234); end
    n_chk++; if (u_if.lo_o !== 32'd0) begin n_fail++; $display("FAIL hilo_lo_hold: got %h want %h", u_if.lo_o, 32'd0); end
    tick();
    set_idle();
    #2;
    n_chk++; if (u_if.hi_o !== 32'h1234) begin n_fail++; $display("FAIL hilo_hi_stored: got %h want %h", u_if.hi_o, 32'h1234); end
    n_chk++; if (u_if.lo_o !== 32'd0) begin n_fail++; $display("FAIL hilo_lo_stored: got %h want %h", u_if.lo_o, 32'd0); end
    n_chk++; if (u_if.hilo_cnt !== 32'd1) begin n_fail++; $display("FAIL hilo_cnt1: got %h want %h", u_if.hilo_cnt, 32'd1); end
    set_bus(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'hA, 32'hB);
    tick();
    set_idle();
    #2;
    n_chk++; if (u_if.hi_o !== 32'hA) begin n_fail++; $display("FAIL hilo_both_hi: got %h want %h", u_if.hi_o, 32'hA); end
    n_chk++; if (u_if.lo_o !== 32'hB) begin n_fail++; $display("FAIL hilo_both_lo: got %h want %h", u_if.lo_o, 32'hB); end
    n_chk++; if (u_if.hilo_cnt !== 32'd2) begin n_fail++; $display("FAIL hilo_cnt2: got %h want %h", u_if.hilo_cnt, 32'd2); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0)
        set_idle();
      else
        set_bus(1'($urandom), wa, $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom);
      u_if.raddr1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      u_if.raddr2 = ($urandom_range(0, 2) == 0) ? u_if.raddr1 : 5'($urandom_range(0, 31));
      #2;
      n_chk++; if (u_if.rdata1 !== exp_rd(u_if.raddr1)) begin n_fail++; $display("FAIL rnd_rdata1 @%0d: got %h want %h", n, u_if.rdata1, exp_rd(u_if.raddr1)); end
      n_chk++; if (u_if.rdata2 !== exp_rd(u_if.raddr2)) begin n_fail++; $display("FAIL rnd_rdata2 @%0d: got %h want %h", n, u_if.rdata2, exp_rd(u_if.raddr2)); end
      n_chk++; if (u_if.hi_o !== exp_hi()) begin n_fail++; $display("FAIL rnd_hi @%0d: got %h want %h", n, u_if.hi_o, exp_hi()); end
      n_chk++; if (u_if.lo_o !== exp_lo()) begin n_fail++; $display("FAIL rnd_lo @%0d: got %h want %h", n, u_if.lo_o, exp_lo()); end
      n_chk++; if (u_if.commit_cnt !== m_cc) begin n_fail++; $display("FAIL rnd_commit_cnt @%0d: got %h want %h", n, u_if.commit_cnt, m_cc); end
      n_chk++; if (u_if.hilo_cnt !== m_hc) begin n_fail++; $display("FAIL rnd_hilo_cnt @%0d: got %h want %h", n, u_if.hilo_cnt, m_hc); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    set_bus(1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0BAD_0001, 32'h0BAD_0002);
    tick();
    set_idle();
    u_if.raddr1 = 5'd12;
    u_if.raddr2 = 5'd12;
    #1;
    n_chk++; if (u_if.rdata1 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL arst_pre: got %h want %h", u_if.rdata1, 32'hCAFEF00D); end
    resetn = 1'b0;
    model_clear();
    #1;
    n_chk++; if (u_if.rdata1 !== 32'd0) begin n_fail++; $display("FAIL arst_rdata1: got %h want %h", u_if.rdata1, 32'd0); end
    n_chk++; if (u_if.hi_o !== 32'd0) begin n_fail++; $display("FAIL arst_hi: got %h want %h", u_if.hi_o, 32'd0); end
    n_chk++; if (u_if.lo_o !== 32'd0) begin n_fail++; $display("FAIL arst_lo: got %h want %h", u_if.lo_o, 32'd0); end
    n_chk++; if (u_if.commit_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_commit_cnt: got %h want %h", u_if.commit_cnt, 32'd0); end
    n_chk++; if (u_if.hilo_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_hilo_cnt: got %h want %h", u_if.hilo_cnt, 32'd0); end
    // a write pending while reset is held is visible through the bypass but never stored
    set_bus(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 32'h77, 32'd0);
    u_if.raddr1 = 5'd9;
    #1;
    n_chk++; if (u_if.rdata1 !== 32'h99) begin n_fail++; $display("FAIL arst_byp_rd: got %h want %h", u_if.rdata1, 32'h99); end
    n_chk++; if (u_if.hi_o !== 32'h77) begin n_fail++; $display("FAIL arst_byp_hi: got %h want %h", u_if.hi_o, 32'h77); end
    tick();
    set_idle();
    resetn = 1'b1;
    #2;
    n_chk++; if (u_if.rdata1 !== 32'd0) begin n_fail++; $display("FAIL arst_lost_rd: got %h want %h", u_if.rdata1, 32'd0); end
    n_chk++; if (u_if.hi_o !== 32'd0) begin n_fail++; $display("FAIL arst_lost_hi: got %h want %h", u_if.hi_o, 32'd0); end
    n_chk++; if (u_if.commit_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_lost_cnt: got %h want %h", u_if.commit_cnt, 32'd0); end
    set_bus(1'b1, 5'd9, 32'h5A, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    set_idle();
    #2;
    n_chk++; if (u_if.rdata1 !== 32'h5A) begin n_fail++; $display("FAIL arst_first_wr: got %h want %h", u_if.rdata1, 32'h5A); end
    n_chk++; if (u_if.commit_cnt !== 32'd1) begin n_fail++; $display("FAIL arst_first_cnt: got %h want %h", u_if.commit_cnt, 32'd1); end
  endtask

  task automatic test_counter_wrap();
    force dut.r_commit_cnt = 32'hFFFFFFFF;
    force dut.u_hilo.r_hilo_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_commit_cnt;
    release dut.u_hilo.r_hilo_cnt;
    m_cc = 32'hFFFFFFFF;
    m_hc = 32'hFFFFFFFF;
    set_bus(1'b1, 5'd4, 32'h4444, 1'b0, 1'b1, 32'd0, 32'h1);
    #1;
    n_chk++; if (u_if.commit_cnt !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_pre: got %h want %h", u_if.commit_cnt, 32'hFFFFFFFF); end
    tick();
    set_idle();
    #2;
    n_chk++; if (u_if.commit_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_commit_cnt: got %h want %h", u_if.commit_cnt, 32'd0); end
    n_chk++; if (u_if.hilo_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_hilo_cnt: got %h want %h", u_if.hilo_cnt, 32'd0); end
    tick();
    #2;
    n_chk++; if (u_if.commit_cnt !== 32'd0) begin n_fail++; $display("FAIL bubble_no_count: got %h want %h", u_if.commit_cnt, 32'd0); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_hilo();
    test_random();
    test_async_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
